wide_adder_sequencer: RTL and testbench
=======================================

# wide_adder_sequencer

Multi-word adder controller that computes a (16·WORDS)-bit sum by sequencing a single `adder_16bit` instance over WORDS cycles. The carry is chained through a register between limbs. Operands enter and results leave through valid/ready handshakes. It sits between a wide-operand producer and consumer wherever a full-width adder is too large, trading latency for area.

## Interface
Parameters:
- `WORDS`, 4: number of 16-bit limbs; legal range 2–16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block accepts operands; equals (state == IDLE).
- `in_a` in 16·WORDS: operand A, limb 0 = bits [15:0].
- `in_b` in 16·WORDS: operand B.
- `in_cin` in 1: carry into limb 0.
- `in_sub` in 1: subtract request; present only with `ADDSEQ_SUB_EN`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out 16·WORDS: registered full-width sum.
- `out_cout` out 1: carry out of the top limb.
- `out_overflow` out 1: signed overflow of the full-width operation.
- `busy` out 1: high in RUN or DONE.

## Operation
- Internally instantiates one `adder_16bit`. Its `a`, `b` and `cin` inputs are driven by the limb mux at index `idx` and by the carry register `c_q`.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - On `in_valid && in_ready`: latch `in_a` and `in_b` into operand registers, set `c_q <= in_cin`, set `idx <= 0`, and go to RUN.
- **RUN**, every cycle:
  - `out_sum[16·idx +: 16] <= adder sum`.
  - `c_q <= adder cout`.
  - `idx <= idx + 1`.
- **RUN exit**, when `idx == WORDS-1`:
  - Load `out_cout` with the adder `cout`.
  - Load `out_overflow` with the adder `overflow`, which is the sign test of the top limb and therefore valid for the full width.
  - Go to DONE.
- **DONE**
  - `out_valid = 1`.
  - `out_sum`, `out_cout` and `out_overflow` stay stable until `out_ready` is sampled high, then go to IDLE.
- No new operand is accepted outside IDLE. `in_valid` is ignored while `busy`.
- Arithmetic is modulo 2^(16·WORDS). `out_cout` is the unsigned carry; `out_overflow` is the two's-complement overflow.
- `idx` width is clog2(WORDS). It never wraps past WORDS-1.

## Timing
- Reset values:
  - state = IDLE, so `in_ready = 1` once `rst` drops.
  - `idx = 0`, `c_q = 0`.
  - `out_valid = 0`, `out_sum = 0`, `out_cout = 0`, `out_overflow = 0`, `busy = 0`.
  - While `rst` is high, `in_ready` reads 1 but no transfer occurs.
- Acceptance edge E0. Limbs 0..WORDS-1 are processed on edges E1..E(WORDS). `out_valid` rises after E(WORDS), giving a latency of WORDS cycles.
- The output handshake completes on the edge where `out_valid && out_ready`. `in_ready` is high in the following cycle, so minimum initiation interval is WORDS+2 cycles.
- If `out_ready` is already high when DONE is entered, DONE lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE immediately clears all state. The partial result is discarded and no `out_valid` pulse is produced.
- `out_sum` limbs above `idx` keep their old values during RUN. Only the value under `out_valid` is defined.

## Configuration
- Macro: `ADDSEQ_SUB_EN`.
- **Defined**
  - Port `in_sub` exists and is latched at acceptance.
  - When `in_sub = 1`, the B limbs are fed to the adder inverted, `c_q` is initialised to 1 and `in_cin` is ignored, so the result is A − B.
  - `out_cout = 1` means no borrow.
  - `out_overflow` reports signed subtraction overflow.
- **Undefined**
  - `in_sub` is absent; addition only.

## Test plan
WORDS = 4 unless noted.
- **Carry across limbs:** A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → `out_sum` = 0x0000_0000_0001_0000, cout=0, ovf=0; `out_valid` asserted exactly 4 cycles after the accept edge.
- **Full carry ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum=0, cout=1, ovf=0.
- **Signed overflow:** A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles in DONE while pulsing `in_valid` → outputs stable, `in_ready` = 0, no second transfer; raise `out_ready` → IDLE next cycle, `in_ready` = 1, then a second transaction completes correctly.
- **Reset mid-run:** assert `rst` after 2 RUN cycles → all outputs at reset values immediately, no `out_valid`; the next transaction (A=3, B=4) gives sum=7.
- **Subtraction** (`ADDSEQ_SUB_EN`): A=5, B=7, `in_sub` = 1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; A=0x8000_0000_0000_0000, B=1 → ovf=1.

Source files
------------

// File: rtl/wide_adder_sequencer.sv
// ---------------------------------------------------------------------------
// wide_adder_sequencer
//
// Purpose:
//   Computes a (16*WORDS)-bit sum by running one 16-bit adder over WORDS
//   cycles, limb 0 first. The carry between limbs is held in a register.
//   Operands are accepted and results delivered through valid/ready
//   handshakes.
//
// Optional feature:
//   `define ADDSEQ_SUB_EN adds port in_sub. When in_sub is high at acceptance,
//   the result is A - B. In that case out_cout = 1 means no borrow.
//
// Parameters:
//   WORDS        number of 16-bit limbs (2..16)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand request
//   in_ready     high in IDLE (operands accepted)
//   in_a, in_b   operands, limb 0 = bits [15:0]
//   in_cin       carry into limb 0 (ignored for subtraction)
//   in_sub       subtract request (ADDSEQ_SUB_EN only)
//   out_valid    result available (DONE)
//   out_ready    consumer takes the result
//   out_sum      registered full-width sum
//   out_cout     unsigned carry out of the top limb
//   out_overflow two's-complement overflow of the full-width operation
//   busy         high in RUN or DONE
// ---------------------------------------------------------------------------

module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        overflow
);

   // 16-bit add with carry, plus a signed-overflow test on the sign bits
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      overflow    = (a[15] == b[15]) && (sum[15] != a[15]);
   end

endmodule

module wide_adder_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   in_a,
   input  logic [16*WORDS-1:0]   in_b,
   input  logic                  in_cin,
`ifdef ADDSEQ_SUB_EN
   input  logic                  in_sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  out_overflow,
   output logic                  busy
);

   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            carry_r;
   logic [IW-1:0]   idx_r;
   logic            last_s;
   logic [15:0]     limb_a_s;
   logic [15:0]     limb_b_s;
   logic            carry_init_s;
   logic            sub_s;
   logic [15:0]     add_sum_s;
   logic            add_cout_s;
   logic            add_ovf_s;

`ifdef ADDSEQ_SUB_EN
   logic            sub_r;
   assign sub_s        = sub_r;
   // Subtraction is A + ~B + 1, so the incoming carry is forced to one.
   assign carry_init_s = in_sub ? 1'b1 : in_cin;
`else
   assign sub_s        = 1'b0;
   assign carry_init_s = in_cin;
`endif

   assign last_s   = (idx_r == IW'(WORDS - 1));
   // {idx, 4'b0} is 16*idx without a multiplier.
   assign limb_a_s = a_r[{idx_r, 4'b0000} +: 16];
   assign limb_b_s = b_r[{idx_r, 4'b0000} +: 16] ^ {16{sub_s}};

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign busy      = (state_r == RUN) || (state_r == DONE);

   adder_16bit u_adder (
      .a        (limb_a_s),
      .b        (limb_b_s),
      .cin      (carry_r),
      .sum      (add_sum_s),
      .cout     (add_cout_s),
      .overflow (add_ovf_s)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) next_state_s = RUN;
            else          next_state_s = IDLE;
         end
         RUN: begin
            if (last_s) next_state_s = DONE;
            else        next_state_s = RUN;
         end
         DONE: begin
            if (out_ready) next_state_s = IDLE;
            else           next_state_s = DONE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Operand capture, limb sequencing and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r          <= '0;
         b_r          <= '0;
         carry_r      <= 1'b0;
         idx_r        <= '0;
         out_sum      <= '0;
         out_cout     <= 1'b0;
         out_overflow <= 1'b0;
`ifdef ADDSEQ_SUB_EN
         sub_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= in_a;
                  b_r     <= in_b;
                  carry_r <= carry_init_s;
                  idx_r   <= '0;
`ifdef ADDSEQ_SUB_EN
                  sub_r   <= in_sub;
`endif
               end
            end
            RUN: begin
               out_sum[{idx_r, 4'b0000} +: 16] <= add_sum_s;
               carry_r <= add_cout_s;
               if (last_s) begin
                  // Top limb: its sign test is the full-width overflow.
                  out_cout     <= add_cout_s;
                  out_overflow <= add_ovf_s;
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            DONE: begin
               // Results held until the consumer takes them.
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_adder_sequencer
//
// Self-checking bench for wide_adder_sequencer with WORDS = 4. It runs
// directed vectors from a table, then handshake and reset corner
// sequences, then random transactions checked against an arithmetic model.
// Define ADDSEQ_SUB_EN to also cover subtraction.
// ---------------------------------------------------------------------------

module tb_wide_adder_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
`ifdef ADDSEQ_SUB_EN
   logic          in_sub;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_overflow;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   wide_adder_sequencer #(.WORDS(WORDS)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_cin       (in_cin),
`ifdef ADDSEQ_SUB_EN
      .in_sub       (in_sub),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_cout     (out_cout),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic; overflow from a sign-extended result.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0]   u;
      logic [W+1:0] sx;
      if (sub) begin
         u  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         sx = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b};
      end else begin
         u  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         sx = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + (W+2)'(cin);
      end
      s  = u[W-1:0];
      co = u[W];
      ov = (sx[W+1:W-1] != 3'b000) && (sx[W+1:W-1] != 3'b111);
   endfunction

   // Wait for in_ready, present operands for one accept edge, return at the
   // falling edge after acceptance.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_before_send", W'(in_ready), W'(1));
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
`ifdef ADDSEQ_SUB_EN
      in_sub   = sub;
`endif
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_after_accept", W'(busy), W'(1));
   endtask

   task automatic wait_done();
      int lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", W'(lat), W'(WORDS));
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] s,
                               input logic co, input logic ov);
      chk({tag, "_sum"}, out_sum, s);
      chk({tag, "_cout"}, W'(out_cout), W'(co));
      chk({tag, "_ovf"}, W'(out_overflow), W'(ov));
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drops_after_take", W'(out_valid), W'(0));
      chk("ready_after_take", W'(in_ready), W'(1));
   endtask

   initial begin
      vec_t         vecs[$];
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      bit           seen;

      vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0});
      vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
      vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1});
      vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 64'h2222_2222_2222_2212, 1'b0, 1'b0});
`ifdef ADDSEQ_SUB_EN
      vecs.push_back('{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
      vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
`ifdef ADDSEQ_SUB_EN
      in_sub    = 1'b0;
`endif
      out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      check_result("rst", '0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         chk("in_ready_low_in_run", W'(in_ready), W'(0));
         wait_done();
         check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
         take();
      end

      // Backpressure: results held, no second transfer while DONE
      send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
      wait_done();
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_a     = {$urandom, $urandom};
         in_b     = {$urandom, $urandom};
         @(negedge clk);
         chk("bp_valid_held", W'(out_valid), W'(1));
         chk("bp_in_ready_low", W'(in_ready), W'(0));
         chk("bp_sum_stable", out_sum, 64'h0000_0000_0001_0000);
      end
      in_valid = 1'b0;
      take();
      send(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0005, 1'b0, 1'b0);
      wait_done();
      check_result("bp_second", 64'h0000_0003_0000_0005, 1'b0, 1'b0);
      take();

      // out_ready already high: DONE lasts exactly one cycle
      out_ready = 1'b1;
      send(64'h10, 64'h20, 1'b0, 1'b0);
      wait_done();
      chk("oneshot_sum", out_sum, 64'h30);
      @(negedge clk);
      chk("oneshot_done_one_cycle", W'(out_valid), W'(0));
      out_ready = 1'b0;

      // Reset after two RUN cycles
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", W'(out_valid), W'(0));
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_in_ready", W'(in_ready), W'(1));
      check_result("midrst", '0, 1'b0, 1'b0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_valid_pulse", W'(seen), W'(0));
      send(64'h3, 64'h4, 1'b0, 1'b0);
      wait_done();
      check_result("post_rst", 64'h7, 1'b0, 1'b0);
      take();

      // Random transactions against the model
      for (int i = 0; i < 25; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         if (i % 5 == 0) rb = ~ra;
         model(ra, rb, rc, rs, es, ec, eo);
         send(ra, rb, rc, rs);
         wait_done();
         check_result($sformatf("rand%0d", i), es, ec, eo);
         take();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
